// File: rtl/reflet_int_ctrl_pkg.sv
// Shared constants for the reflet interrupt controller: register map,
// FSM state encoding and the STATUS word layout.
package reflet_int_ctrl_pkg;

  localparam int MAX_SOURCES = 8;

  localparam logic [1:0] REG_MASK    = 2'd0;
  localparam logic [1:0] REG_PENDING = 2'd1;
  localparam logic [1:0] REG_MODE    = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  function automatic logic [7:0] status_word(input state_t st, input logic [2:0] id);
    return {st, 3'b000, id};
  endfunction

endpackage

// File: rtl/reflet_prio_encoder.sv
// Fixed-priority encoder: reports whether any bit is set and the lowest set index.
module reflet_prio_encoder
  import reflet_int_ctrl_pkg::*;
(
  input  logic [MAX_SOURCES-1:0] vec,
  output logic                   any,
  output logic [2:0]             idx
);

  always_comb begin
    any = |vec;
    idx = '0;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = MAX_SOURCES - 1; i >= 0; i--) begin
      if (vec[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/reflet_int_ctrl.sv
// Memory-mapped interrupt controller: per-source mask, edge/level capture,
// fixed-priority request to the CPU with ack / end-of-interrupt handshake.
module reflet_int_ctrl
  import reflet_int_ctrl_pkg::*;
#(
  parameter int base_addr_size = 16,
  parameter int base_addr      = 0,
  parameter int nb_sources     = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [nb_sources-1:0]     irq_in,
  output logic                      interrupt,
  output logic [2:0]                int_id,
  input  logic                      int_ack,
  input  logic [base_addr_size-1:0] addr,
  input  logic                      write_en,
  input  logic [7:0]                data_in,
  output logic [7:0]                data_out
);

  localparam logic [base_addr_size-1:0] BASE = base_addr_size'(base_addr);

  logic [nb_sources-1:0]     mask;
  logic [nb_sources-1:0]     mode;
  logic [nb_sources-1:0]     pending;
  logic [nb_sources-1:0]     irq_q;
  logic [nb_sources-1:0]     pending_next;
  logic [nb_sources-1:0]     edge_set;
  logic [nb_sources-1:0]     edge_clr;
  logic [MAX_SOURCES-1:0]    ack_hot;
  logic [MAX_SOURCES-1:0]    req_vec;
  logic [base_addr_size-1:0] offset;
  logic [1:0]                reg_sel;
  logic                      in_win;
  logic                      bus_wr;
  logic                      ack_fire;
  logic                      req_any;
  logic [2:0]                req_idx;
  state_t                    state;

  // Unsigned wrap of the subtraction makes addresses below the base fall outside.
  assign offset  = addr - BASE;
  assign in_win  = offset < base_addr_size'(4);
  assign reg_sel = offset[1:0];
  assign bus_wr  = enable & write_en & in_win;

  assign ack_fire = (state == REQ) & int_ack;
  assign ack_hot  = ack_fire ? (MAX_SOURCES'(1) << int_id) : '0;

  // Edge-mode bits: a fresh edge beats any clear arriving in the same cycle.
  assign edge_set     = mode & irq_in & ~irq_q;
  assign edge_clr     = ((bus_wr && reg_sel == REG_PENDING) ? data_in[nb_sources-1:0] : '0)
                      | ack_hot[nb_sources-1:0];
  assign pending_next = (mode & (edge_set | (pending & ~edge_clr))) | (~mode & irq_in);

  assign req_vec = MAX_SOURCES'(pending & mask);

  reflet_prio_encoder u_prio (
    .vec (req_vec),
    .any (req_any),
    .idx (req_idx)
  );

  always_comb begin
    data_out = '0;
    if (enable && in_win) begin
      unique case (reg_sel)
        REG_MASK:    data_out = 8'(mask);
        REG_PENDING: data_out = 8'(pending);
        REG_MODE:    data_out = 8'(mode);
        REG_STATUS:  data_out = status_word(state, int_id);
        default:     data_out = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask      <= '0;
      mode      <= '0;
      pending   <= '0;
      irq_q     <= '0;
      state     <= IDLE;
      interrupt <= 1'b0;
      int_id    <= '0;
    end else begin
      irq_q   <= irq_in;
      pending <= pending_next;
      if (bus_wr && reg_sel == REG_MASK) mask <= data_in[nb_sources-1:0];
      if (bus_wr && reg_sel == REG_MODE) mode <= data_in[nb_sources-1:0];

      unique case (state)
        IDLE: begin
          if (enable && req_any) begin
            int_id    <= req_idx;
            interrupt <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (int_ack) begin
            interrupt <= 1'b0;
            state     <= SERVICE;
          end
        end
        SERVICE: begin
          if (bus_wr && reg_sel == REG_STATUS) state <= IDLE;
        end
        default: begin
          interrupt <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reflet_int_ctrl.sv
// Bench for reflet_int_ctrl: directed scenarios plus randomized traffic,
// scored against a cycle-level reference model through expectation queues.
module tb_reflet_int_ctrl;

  localparam logic [15:0] BASE = 16'h0040;
  localparam logic [15:0] IDLE_ADDR = 16'h0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic [7:0]  irq_in = '0;
  logic        interrupt;
  logic [2:0]  int_id;
  logic        int_ack = 1'b0;
  logic [15:0] addr = IDLE_ADDR;
  logic        write_en = 1'b0;
  logic [7:0]  data_in = '0;
  logic [7:0]  data_out;

  always #5 clk = ~clk;

  reflet_int_ctrl #(
    .base_addr_size(16),
    .base_addr     (64),
    .nb_sources    (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .irq_in    (irq_in),
    .interrupt (interrupt),
    .int_id    (int_id),
    .int_ack   (int_ack),
    .addr      (addr),
    .write_en  (write_en),
    .data_in   (data_in),
    .data_out  (data_out)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state (0 = idle, 1 = requesting, 2 = in service).
  bit [7:0] m_mask = '0, m_mode = '0, m_pend = '0, m_prev = '0;
  int       m_state = 0;
  bit [2:0] m_id = '0;
  bit       m_irq = 1'b0;

  logic [7:0] q_rd[$];
  int         q_id[$];
  bit         rd_vld = 1'b0;
  bit         int_seen = 1'b0;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit in_win(input logic [15:0] a);
    return (a >= BASE) && (a < BASE + 16'd4);
  endfunction

  function automatic logic [7:0] model_read();
    if (!enable || !in_win(addr)) return 8'h00;
    case (int'(addr) - int'(BASE))
      0:       return m_mask;
      1:       return m_pend;
      2:       return m_mode;
      default: return {2'(m_state), 3'b000, m_id};
    endcase
  endfunction

  task automatic model_step();
    bit [7:0] np;
    bit       wsel, set_b, clr_b;
    int       off, lo;
    if (reset) begin
      m_mask = '0; m_mode = '0; m_pend = '0; m_prev = '0;
      m_state = 0; m_id = '0; m_irq = 1'b0;
      return;
    end
    wsel = enable && write_en && in_win(addr);
    off  = int'(addr) - int'(BASE);
    for (int i = 0; i < 8; i++) begin
      if (m_mode[i]) begin
        set_b = irq_in[i] && !m_prev[i];
        clr_b = (wsel && off == 1 && data_in[i]) ||
                (m_state == 1 && int_ack && int'(m_id) == i);
        np[i] = set_b || (m_pend[i] && !clr_b);
      end else begin
        np[i] = irq_in[i];
      end
    end
    case (m_state)
      0: begin
        lo = -1;
        for (int i = 7; i >= 0; i--) if (m_pend[i] && m_mask[i]) lo = i;
        if (enable && lo >= 0) begin
          m_state = 1; m_id = 3'(lo); m_irq = 1'b1;
          q_id.push_back(lo);
        end
      end
      1: if (int_ack) begin m_state = 2; m_irq = 1'b0; end
      2: if (wsel && off == 3) m_state = 0;
      default: m_state = 0;
    endcase
    if (wsel && off == 0) m_mask = data_in;
    if (wsel && off == 2) m_mode = data_in;
    m_prev = irq_in;
    m_pend = np;
  endtask

  always @(posedge clk) model_step();

  // Monitor: lockstep on the CPU-side outputs, queue-driven for reads and requests.
  always @(negedge clk) begin
    chk("interrupt", int'(interrupt), int'(m_irq));
    chk("int_id", int'(int_id), int'(m_id));
    if (interrupt && !int_seen) begin
      if (q_id.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL irq_event: interrupt rose with id %0d but no request was expected", int_id);
      end else begin
        chk("irq_event_id", int'(int_id), q_id.pop_front());
      end
    end
    int_seen = interrupt;
    if (rd_vld) begin
      if (q_rd.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL data_out: read strobe with empty expectation queue, got 0x%0h", data_out);
      end else begin
        chk("data_out", int'(data_out), int'(q_rd.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int off, input logic [7:0] val);
    addr = BASE + 16'(off); data_in = val; write_en = 1'b1;
    tick();
    write_en = 1'b0; addr = IDLE_ADDR;
  endtask

  task automatic rd(input int off);
    addr = BASE + 16'(off);
    q_rd.push_back(model_read());
    rd_vld = 1'b1;
    tick();
    rd_vld = 1'b0; addr = IDLE_ADDR;
  endtask

  task automatic peek(input int off, input int exp, input string name);
    addr = BASE + 16'(off);
    #1;
    chk(name, int'(data_out), exp);
    addr = IDLE_ADDR;
  endtask

  task automatic ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  initial begin
    // Reset and register defaults
    tick(); tick();
    reset = 1'b0;
    for (int r = 0; r < 4; r++) rd(r);
    chk("rst_irq", int'(interrupt), 0);
    peek(3, 8'h00, "rst_status");

    // Edge-mode single source
    wr(0, 8'h05); wr(2, 8'hFF);
    irq_in = 8'h04; tick(); irq_in = 8'h00;
    peek(1, 8'h04, "seq1_pending");
    chk("seq1_irq_early", int'(interrupt), 0);
    tick();
    chk("seq1_irq", int'(interrupt), 1);
    chk("seq1_id", int'(int_id), 2);
    ack();
    chk("seq1_irq_acked", int'(interrupt), 0);
    peek(1, 8'h00, "seq1_pend_cleared");
    peek(3, 8'h82, "seq1_status");
    wr(3, 8'h00); tick();

    // Priority, no nesting
    wr(0, 8'hFF);
    irq_in = 8'h22; tick(); irq_in = 8'h00; tick();
    chk("prio_id", int'(int_id), 1);
    ack(); tick();
    chk("prio_no_nest", int'(interrupt), 0);
    wr(3, 8'h00);
    chk("prio_eoi_same", int'(interrupt), 0);
    tick();
    chk("prio_second_irq", int'(interrupt), 1);
    chk("prio_second_id", int'(int_id), 5);
    ack(); wr(3, 8'h00); tick();

    // Masked source, unmask later, clear while requesting
    wr(0, 8'h00);
    irq_in = 8'h08; tick(); irq_in = 8'h00; tick();
    chk("mask_blocks", int'(interrupt), 0);
    peek(1, 8'h08, "mask_pending");
    wr(0, 8'h08); tick();
    chk("unmask_irq", int'(interrupt), 1);
    chk("unmask_id", int'(int_id), 3);
    wr(1, 8'h08);
    chk("req_held", int'(interrupt), 1);
    peek(1, 8'h00, "w1c_pending");
    ack(); wr(3, 8'h00); tick(); tick();
    chk("cleared_no_irq", int'(interrupt), 0);

    // Level mode
    wr(2, 8'h00); wr(0, 8'h01);
    irq_in = 8'h01; tick(); tick();
    chk("lvl_irq", int'(interrupt), 1);
    ack(); wr(3, 8'h00); tick();
    chk("lvl_reassert", int'(interrupt), 1);
    ack(); irq_in = 8'h00; tick(); wr(3, 8'h00); tick();
    chk("lvl_dropped", int'(interrupt), 0);
    peek(1, 8'h00, "lvl_pending");

    // Enable gating and reset during a request
    wr(2, 8'hFF); wr(0, 8'h01);
    enable = 1'b0;
    irq_in = 8'h01; tick(); irq_in = 8'h00; tick(); tick();
    chk("dis_no_irq", int'(interrupt), 0);
    peek(1, 8'h00, "dis_read_zero");
    wr(0, 8'h00);
    enable = 1'b1;
    peek(0, 8'h01, "dis_mask_kept");
    peek(1, 8'h01, "dis_pending_kept");
    tick();
    chk("en_irq", int'(interrupt), 1);
    reset = 1'b1; tick();
    chk("rst_mid_req", int'(interrupt), 0);
    reset = 1'b0; tick();

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      reset    = ($urandom_range(0, 299) == 0);
      enable   = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 3) == 0) irq_in = irq_in ^ (8'($urandom) & 8'($urandom));
      int_ack  = ($urandom_range(0, 4) == 0);
      write_en = ($urandom_range(0, 5) == 0);
      addr     = BASE - 16'd2 + 16'($urandom_range(0, 7));
      data_in  = 8'($urandom);
      q_rd.push_back(model_read());
      rd_vld = 1'b1;
      tick();
    end
    rd_vld = 1'b0; reset = 1'b0; enable = 1'b1; int_ack = 1'b0;
    write_en = 1'b0; addr = IDLE_ADDR; irq_in = '0;
    tick(); tick(); tick();
    chk("rd_queue_drained", q_rd.size(), 0);
    chk("id_queue_drained", q_id.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
